bpuf_eval_ctrl: RTL and testbench

- Initiator side of the multi-bit bistable-ring PUF array.
- Accepts a challenge word over a valid/ready handshake and drives the array's per-bit excite inputs through a relax/excite cycle.
- Samples the asynchronous response through a 2-FF synchroniser, repeats NUM_EVALS times, and emits a per-bit majority-voted response over a second valid/ready handshake.
- Sits between the PUF array top and the CRP logging/key-generation logic.

---
 rtl/bpuf_pkg.sv | 23 ++
 rtl/bpuf_vote_acc.sv | 46 ++++
 rtl/bpuf_eval_ctrl.sv | 179 +++++++++++++++++
 tb/tb_bpuf_eval_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpuf_pkg.sv
// Shared types and defaults for the bistable-ring PUF evaluation controller.
package bpuf_pkg;

    localparam int unsigned DEF_WIDTH         = 33;
    localparam int unsigned DEF_NUM_EVALS     = 5;
    localparam int unsigned DEF_RELAX_CYCLES  = 16;
    localparam int unsigned DEF_SETTLE_CYCLES = 64;

    typedef enum logic [2:0] {
        IDLE,
        RELAX,
        EXCITE,
        CAPTURE,
        VOTE,
        DONE
    } state_t;

    // Bits needed to hold values 0..max_val (vote counters use max_val = NUM_EVALS)
    function automatic int unsigned ctr_w(input int unsigned max_val);
        return (max_val < 2) ? 32'd1 : 32'($clog2(max_val + 1));
    endfunction

endpackage

// File: rtl/bpuf_vote_acc.sv
// Vectorised per-bit vote accumulator with majority and unanimity compare.
// BPUF_UNSTABLE_MASK_EN adds the non-unanimous bit mask output.
module bpuf_vote_acc
    import bpuf_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned NUM_EVALS = DEF_NUM_EVALS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_bits,
`ifdef BPUF_UNSTABLE_MASK_EN
    output logic [WIDTH-1:0] o_unstable_c,
`endif
    output logic [WIDTH-1:0] o_maj_c
);

    localparam int unsigned CW = ctr_w(NUM_EVALS);

    logic [CW-1:0] r_cnt [WIDTH];

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else if (i_inc) begin
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= r_cnt[i] + CW'(i_bits[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            o_maj_c[i] = (r_cnt[i] > CW'(NUM_EVALS / 2));
        end
    end

`ifdef BPUF_UNSTABLE_MASK_EN
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            o_unstable_c[i] = (r_cnt[i] != '0) && (r_cnt[i] != CW'(NUM_EVALS));
        end
    end
`endif

endmodule

// File: rtl/bpuf_eval_ctrl.sv
// Initiator for the bistable-ring PUF array: relax/excite/capture loop with majority vote.
// Optional BPUF_UNSTABLE_MASK_EN exposes resp_unstable (non-unanimous bits).
module bpuf_eval_ctrl
    import bpuf_pkg::*;
#(
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int unsigned NUM_EVALS     = DEF_NUM_EVALS,
    parameter int unsigned RELAX_CYCLES  = DEF_RELAX_CYCLES,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chal_valid,
    output logic             chal_ready,
    input  logic [WIDTH-1:0] chal_in,
    output logic [WIDTH-1:0] puf_chal,
    input  logic [WIDTH-1:0] puf_resp,
    output logic             resp_valid,
    input  logic             resp_ready,
`ifdef BPUF_UNSTABLE_MASK_EN
    output logic [WIDTH-1:0] resp_unstable,
`endif
    output logic [WIDTH-1:0] resp_out,
    output logic             busy
);

    localparam int unsigned PH_MAX = (RELAX_CYCLES > SETTLE_CYCLES) ? RELAX_CYCLES : SETTLE_CYCLES;
    localparam int unsigned PW     = ctr_w(PH_MAX - 1);
    localparam int unsigned EW     = ctr_w(NUM_EVALS);

    if ((NUM_EVALS < 1) || ((NUM_EVALS % 2) == 0)) begin : g_bad_num_evals
        $error("bpuf_eval_ctrl: NUM_EVALS must be odd and >= 1");
    end
    if (RELAX_CYCLES < 1) begin : g_bad_relax
        $error("bpuf_eval_ctrl: RELAX_CYCLES must be >= 1");
    end
    if (SETTLE_CYCLES < 3) begin : g_bad_settle
        $error("bpuf_eval_ctrl: SETTLE_CYCLES must be >= 3");
    end

    state_t           r_state,    w_state_nxt;
    logic [PW-1:0]    r_phase,    w_phase_nxt;
    logic [EW-1:0]    r_eval_cnt, w_eval_nxt;
    logic [WIDTH-1:0] r_chal,     w_chal_nxt;
    logic [WIDTH-1:0] r_resp_out, w_resp_nxt;
    logic [WIDTH-1:0] r_puf_chal, w_puf_chal_nxt;
    logic             r_chal_ready;
    logic             r_resp_valid;
    logic             r_busy;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic             w_acc_clr;
    logic             w_acc_inc;
    logic [WIDTH-1:0] w_maj;

    // Two-flop synchroniser; only r_sync2 reaches the vote logic
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= puf_resp;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_eval_nxt  = r_eval_cnt;
        w_chal_nxt  = r_chal;
        w_resp_nxt  = r_resp_out;
        w_acc_clr   = 1'b0;
        w_acc_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (chal_valid && r_chal_ready) begin
                    w_chal_nxt  = chal_in;
                    w_acc_clr   = 1'b1;
                    w_eval_nxt  = '0;
                    w_phase_nxt = '0;
                    w_state_nxt = RELAX;
                end
            end
            RELAX: begin
                if (r_phase == PW'(RELAX_CYCLES - 1)) begin
                    w_phase_nxt = '0;
                    w_state_nxt = EXCITE;
                end else begin
                    w_phase_nxt = r_phase + PW'(1);
                end
            end
            EXCITE: begin
                if (r_phase == PW'(SETTLE_CYCLES - 1)) begin
                    w_phase_nxt = '0;
                    w_state_nxt = CAPTURE;
                end else begin
                    w_phase_nxt = r_phase + PW'(1);
                end
            end
            CAPTURE: begin
                w_acc_inc  = 1'b1;
                w_eval_nxt = r_eval_cnt + EW'(1);
                w_state_nxt = (r_eval_cnt == EW'(NUM_EVALS - 1)) ? VOTE : RELAX;
            end
            VOTE: begin
                w_resp_nxt  = w_maj;
                w_state_nxt = DONE;
            end
            DONE: begin
                if (resp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // The array only sees the challenge while exciting or being captured
        w_puf_chal_nxt = ((w_state_nxt == EXCITE) || (w_state_nxt == CAPTURE)) ? r_chal : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_phase      <= '0;
            r_eval_cnt   <= '0;
            r_chal       <= '0;
            r_resp_out   <= '0;
            r_puf_chal   <= '0;
            r_chal_ready <= 1'b1;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_eval_cnt   <= w_eval_nxt;
            r_chal       <= w_chal_nxt;
            r_resp_out   <= w_resp_nxt;
            r_puf_chal   <= w_puf_chal_nxt;
            r_chal_ready <= (w_state_nxt == IDLE);
            r_resp_valid <= (w_state_nxt == DONE);
            r_busy       <= (w_state_nxt != IDLE);
        end
    end

`ifdef BPUF_UNSTABLE_MASK_EN
    logic [WIDTH-1:0] w_unstable;
    logic [WIDTH-1:0] r_resp_unstable;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_unstable <= '0;
        end else if (r_state == VOTE) begin
            r_resp_unstable <= w_unstable;
        end
    end

    assign resp_unstable = r_resp_unstable;
`endif

    bpuf_vote_acc #(
        .WIDTH     (WIDTH),
        .NUM_EVALS (NUM_EVALS)
    ) u_vote_acc (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_acc_clr),
        .i_inc        (w_acc_inc),
        .i_bits       (r_sync2),
`ifdef BPUF_UNSTABLE_MASK_EN
        .o_unstable_c (w_unstable),
`endif
        .o_maj_c      (w_maj)
    );

    assign chal_ready = r_chal_ready;
    assign resp_valid = r_resp_valid;
    assign busy       = r_busy;
    assign puf_chal   = r_puf_chal;
    assign resp_out   = r_resp_out;

endmodule

// File: tb/tb_bpuf_eval_ctrl.sv
// Bench for bpuf_eval_ctrl: cycle-offset timeline model plus majority-vote model, and a
// second small-parameter instance for the degenerate single-evaluation corner.
module tb_bpuf_eval_ctrl;

    localparam int N   = 5;
    localparam int R   = 16;
    localparam int S   = 64;
    localparam int P   = R + S + 1;
    localparam int LAT = N * P + 2;

    localparam logic [32:0] KEY     = 33'h1_5A5A_5A5A;
    localparam logic [32:0] NOISE   = 33'h0_DEAD_BEEF;
    localparam logic [32:0] GARBAGE = 33'h0_BAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        chal_valid = 1'b0;
    logic        chal_ready;
    logic [32:0] chal_in = '0;
    logic [32:0] puf_chal;
    logic [32:0] puf_resp = NOISE;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [32:0] resp_out;
    logic        busy;
`ifdef BPUF_UNSTABLE_MASK_EN
    logic [32:0] resp_unstable;
`endif

    logic        chal_valid2 = 1'b0;
    logic        chal_ready2;
    logic [32:0] chal_in2 = '0;
    logic [32:0] puf_chal2;
    logic [32:0] puf_resp2 = NOISE;
    logic        resp_valid2;
    logic        resp_ready2 = 1'b0;
    logic [32:0] resp_out2;
    logic        busy2;
`ifdef BPUF_UNSTABLE_MASK_EN
    logic [32:0] resp_unstable2;
`endif

    always #5 clk = ~clk;

    bpuf_eval_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .chal_valid    (chal_valid),
        .chal_ready    (chal_ready),
        .chal_in       (chal_in),
        .puf_chal      (puf_chal),
        .puf_resp      (puf_resp),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
`ifdef BPUF_UNSTABLE_MASK_EN
        .resp_unstable (resp_unstable),
`endif
        .resp_out      (resp_out),
        .busy          (busy)
    );

    bpuf_eval_ctrl #(
        .WIDTH         (33),
        .NUM_EVALS     (1),
        .RELAX_CYCLES  (1),
        .SETTLE_CYCLES (3)
    ) dut2 (
        .clk           (clk),
        .rst           (rst),
        .chal_valid    (chal_valid2),
        .chal_ready    (chal_ready2),
        .chal_in       (chal_in2),
        .puf_chal      (puf_chal2),
        .puf_resp      (puf_resp2),
        .resp_valid    (resp_valid2),
        .resp_ready    (resp_ready2),
`ifdef BPUF_UNSTABLE_MASK_EN
        .resp_unstable (resp_unstable2),
`endif
        .resp_out      (resp_out2),
        .busy          (busy2)
    );

    // Per-evaluation flip masks (index = evaluation number 1..N)
    logic [32:0] flip [0:7];

    int total = 0;
    int bad   = 0;

    // Timeline model: m_k is the cycle offset from the handshake cycle (k=0)
    bit          m_en  = 1'b0;
    bit          m_run = 1'b0;
    int          m_k   = 0;
    logic [32:0] m_chal = '0;
    logic [32:0] m_exp  = '0;
    logic [32:0] m_unst = '0;

    function automatic logic [32:0] model_vote(input logic [32:0] c, input bit want_unst);
        logic [32:0] r;
        logic [32:0] s;
        int ones;
        r = '0;
        for (int b = 0; b < 33; b++) begin
            ones = 0;
            for (int e = 1; e <= N; e++) begin
                s = c ^ KEY ^ flip[e];
                ones += int'(s[b]);
            end
            r[b] = want_unst ? ((ones != 0) && (ones != N)) : (2 * ones > N);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_en  <= 1'b1;
            m_run <= 1'b0;
            m_k   <= 0;
        end else if (m_en) begin
            if (!m_run) begin
                if (chal_valid) begin
                    m_run  <= 1'b1;
                    m_k    <= 1;
                    m_chal <= chal_in;
                    m_exp  <= model_vote(chal_in, 1'b0);
                    m_unst <= model_vote(chal_in, 1'b1);
                end
            end else if ((m_k >= LAT) && resp_ready) begin
                m_run <= 1'b0;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    // Behavioural PUF: chal ^ KEY with per-evaluation flips, noise while relaxed
    int          puf_ev = 0;
    logic [32:0] prev_pc = '0;
    always @(negedge clk) begin : puf_model
        int ev;
        ev = puf_ev;
        if (!m_run) ev = 0;
        else if ((puf_chal != '0) && (prev_pc == '0)) ev = puf_ev + 1;
        puf_ev  <= ev;
        prev_pc <= puf_chal;
        puf_resp <= (puf_chal == '0) ? NOISE : (puf_chal ^ KEY ^ flip[ev % 8]);
    end

    always @(negedge clk) begin
        puf_resp2 <= (puf_chal2 == '0) ? NOISE : (puf_chal2 ^ KEY);
    end

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle and compare the main instance against the timeline model
    task automatic step();
        logic [32:0] exp_pc;
        @(negedge clk);
        if (m_en) begin
            exp_pc = '0;
            if (m_run && (m_k <= N * P) && (((m_k - 1) % P) >= R)) exp_pc = m_chal;
            check("chal_ready", 33'(chal_ready), 33'(!m_run));
            check("busy",       33'(busy),       33'(m_run));
            check("resp_valid", 33'(resp_valid), 33'(m_run && (m_k >= LAT)));
            check("puf_chal",   puf_chal,        exp_pc);
            if (m_run && (m_k >= LAT)) begin
                check("resp_out", resp_out, m_exp);
`ifdef BPUF_UNSTABLE_MASK_EN
                check("resp_unstable", resp_unstable, m_unst);
`endif
            end
        end
    endtask

    task automatic send(input logic [32:0] c);
        int n;
        n = 0;
        chal_in    = c;
        chal_valid = 1'b1;
        while (!chal_ready && (n < 2000)) begin
            step();
            n++;
        end
        check("accept_wait", 33'(n < 2000), 33'd1);
        step();
        chal_valid = 1'b0;
        chal_in    = GARBAGE;
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 1;
        while (!resp_valid && (k < 1000)) begin
            step();
            k++;
        end
        check({name, "_latency"}, 33'(k), 33'd407);
    endtask

    task automatic take(input logic [32:0] exp, input string name);
        check(name, resp_out, exp);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check({name, "_drop"}, 33'(resp_valid), 33'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k2;
        for (int i = 0; i < 8; i++) flip[i] = '0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("rst_chal_ready", 33'(chal_ready), 33'd1);
        check("rst_busy",       33'(busy),       33'd0);
        check("rst_resp_valid", 33'(resp_valid), 33'd0);
        check("rst_puf_chal",   puf_chal,        33'd0);
        check("rst_resp_out",   resp_out,        33'd0);
        check("rst_chal_ready2", 33'(chal_ready2), 33'd1);

        // Basic pass-through
        send(33'h0_0000_00FF);
        wait_valid("basic");
        take(33'h1_5A5A_5AA5, "basic_resp");

        // Bit 0 flipped on evaluations 2 and 4: majority keeps the stable value
        flip[2] = 33'h1;
        flip[4] = 33'h1;
        send(33'h0_0000_00FF);
        wait_valid("maj");
`ifdef BPUF_UNSTABLE_MASK_EN
        check("maj_unstable", resp_unstable, 33'h0_0000_0001);
`endif
        take(33'h1_5A5A_5AA5, "maj_resp");
        for (int i = 0; i < 8; i++) flip[i] = '0;

        // Bit 7 flipped on evaluations 1, 3, 5: majority follows the flip
        flip[1] = 33'h80;
        flip[3] = 33'h80;
        flip[5] = 33'h80;
        send(33'h1_0F0F_0000);
        wait_valid("minor");
`ifdef BPUF_UNSTABLE_MASK_EN
        check("minor_unstable", resp_unstable, 33'h0_0000_0080);
`endif
        take(33'h0_5555_5ADA, "minor_resp");
        for (int i = 0; i < 8; i++) flip[i] = '0;

        // Backpressure with a second challenge offered during DONE
        send(33'h1_FFFF_FFFF);
        wait_valid("bp1");
        chal_in    = 33'h0_1234_5678;
        chal_valid = 1'b1;
        repeat (100) step();
        check("bp_resp_held", resp_out, 33'h0_A5A5_A5A5);
        check("bp_chal_ready", 33'(chal_ready), 33'd0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("bp_valid_drop", 33'(resp_valid), 33'd0);
        check("bp_ready_back", 33'(chal_ready), 33'd1);
        step();
        chal_valid = 1'b0;
        chal_in    = GARBAGE;
        check("bp_second_busy", 33'(busy), 33'd1);
        wait_valid("bp2");
        take(33'h1_486E_0C22, "bp2_resp");

        // Reset during the third EXCITE window (k = 189)
        send(33'h0_0F0F_F0F0);
        repeat (188) step();
        check("excite3_chal", puf_chal, 33'h0_0F0F_F0F0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_puf_chal",   puf_chal,         33'd0);
        check("mr_busy",       33'(busy),        33'd0);
        check("mr_chal_ready", 33'(chal_ready),  33'd1);
        check("mr_resp_valid", 33'(resp_valid),  33'd0);
        check("mr_resp_out",   resp_out,         33'd0);
        send(33'h0_0000_00FF);
        wait_valid("after_rst");
        take(33'h1_5A5A_5AA5, "after_rst_resp");

        // Degenerate instance: one evaluation, latency 1*(1+3+1)+2 = 7
        check("c_ready", 33'(chal_ready2), 33'd1);
        chal_in2    = 33'h1_2345_6789;
        chal_valid2 = 1'b1;
        step();
        chal_valid2 = 1'b0;
        chal_in2    = GARBAGE;
        k2 = 1;
        while (!resp_valid2 && (k2 < 100)) begin
            step();
            k2++;
        end
        check("c_latency", 33'(k2), 33'd7);
        check("c_resp", resp_out2, 33'h0_791F_3DD3);
        resp_ready2 = 1'b1;
        step();
        resp_ready2 = 1'b0;
        check("c_drop", 33'(resp_valid2), 33'd0);
        check("c_idle", 33'(busy2), 33'd0);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
